// File: rtl/rv32_pkg.sv
// Shared RV32IM encodings: opcodes, ALU/branch/writeback selects, immediate formats.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // ALU select: [5]=pass op2, [4]=M-extension, [3]=alt, [2:0]=funct3
  localparam logic [5:0] ALU_ADD    = 6'b000000;
  localparam logic [5:0] ALU_PASS_B = 6'b100000;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_JUMP = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    WB_PC4 = 2'd0,
    WB_MEM = 2'd1,
    WB_ALU = 2'd2
  } wb_sel_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

  typedef struct packed {
    logic [5:0] alu_sel;
    logic       op1_pc;
    logic       op2_imm;
    logic       jalr;
    logic [3:0] branch_sel;
    logic [3:0] mem_read;
    logic [2:0] mem_write;
    logic       reg_write_en;
    wb_sel_t    wb_sel;
  } ctrl_t;

  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] i, input imm_fmt_t fmt);
    case (fmt)
      IMM_I:   imm_gen = {{20{i[31]}}, i[31:20]};
      IMM_S:   imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm_gen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   imm_gen = {i[31:12], 12'b0};
      IMM_J:   imm_gen = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm_gen = '0;
    endcase
  endfunction

endpackage

// File: rtl/rv32_alu_core.sv
// Combinational RV32IM ALU: base integer ops plus MUL/DIV family.
module rv32_alu_core
  import rv32_pkg::*;
(
  input  logic [5:0]      alu_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result
);

  logic [2:0]         f3;
  logic [4:0]         shamt;
  logic [XLEN:0]      a_ext;
  logic [XLEN:0]      b_ext;
  logic signed [65:0] product;
  logic               a_neg;
  logic               b_neg;
  logic [XLEN-1:0]    a_mag;
  logic [XLEN-1:0]    b_mag;
  logic [XLEN-1:0]    uq;
  logic [XLEN-1:0]    ur;
  logic [XLEN-1:0]    sq;
  logic [XLEN-1:0]    sr;

  assign f3    = alu_sel[2:0];
  assign shamt = op_b[4:0];

  // 33-bit operands let one signed multiplier cover MULH/MULHSU/MULHU
  always_comb begin
    a_ext   = {(f3 != 3'b011) & op_a[XLEN-1], op_a};
    b_ext   = {~f3[1] & op_b[XLEN-1], op_b};
    product = $signed(a_ext) * $signed(b_ext);
  end

  // Signed divide via magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0
  always_comb begin
    a_neg = op_a[XLEN-1];
    b_neg = op_b[XLEN-1];
    a_mag = a_neg ? XLEN'(-op_a) : op_a;
    b_mag = b_neg ? XLEN'(-op_b) : op_b;
    uq    = '0;
    ur    = '0;
    if (f3[0]) begin
      if (op_b != '0) begin
        uq = op_a / op_b;
        ur = op_a % op_b;
      end
    end else if (b_mag != '0) begin
      uq = a_mag / b_mag;
      ur = a_mag % b_mag;
    end
    sq = (a_neg ^ b_neg) ? XLEN'(-uq) : uq;
    sr = a_neg ? XLEN'(-ur) : ur;
  end

  always_comb begin
    result = '0;
    if (alu_sel[5]) begin
      result = op_b;
    end else if (alu_sel[4]) begin
      case (f3)
        3'b000:  result = product[31:0];
        3'b001,
        3'b010,
        3'b011:  result = product[63:32];
        3'b100:  result = (op_b == '0) ? '1 : sq;
        3'b101:  result = (op_b == '0) ? '1 : uq;
        3'b110:  result = (op_b == '0) ? op_a : sr;
        default: result = (op_b == '0) ? op_a : ur;
      endcase
    end else begin
      case (f3)
        3'b000:  result = alu_sel[3] ? XLEN'(op_a - op_b) : XLEN'(op_a + op_b);
        3'b001:  result = op_a << shamt;
        3'b010:  result = XLEN'($signed(op_a) < $signed(op_b));
        3'b011:  result = XLEN'(op_a < op_b);
        3'b100:  result = op_a ^ op_b;
        3'b101:  result = alu_sel[3] ? XLEN'($signed(op_a) >>> shamt) : (op_a >> shamt);
        3'b110:  result = op_a | op_b;
        default: result = op_a & op_b;
      endcase
    end
  end

endmodule

// File: rtl/rv32_decode_execute.sv
// RV32IM decode + ID/EX register + execute (ALU, branch decision).
module rv32_decode_execute
  import rv32_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  input  logic [31:0]     INSTRUCTION,
  input  logic [XLEN-1:0] PC_IN,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  input  logic            STALL,
  output logic [XLEN-1:0] ALU_OUT,
  output logic            BRANCH_TAKEN,
  output logic [3:0]      MEM_READ,
  output logic [2:0]      MEM_WRITE,
  output logic            REG_WRITE_EN,
  output logic [1:0]      REG_WRITE_SELECT,
  output logic [4:0]      RD_ADDR
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  ctrl_t           id_ctrl;
  ctrl_t           cap_ctrl;
  imm_fmt_t        imm_fmt;
  logic [XLEN-1:0] id_imm;

  ctrl_t           ex_ctrl;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_data1;
  logic [XLEN-1:0] ex_data2;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rd;

  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] alu_res;
  logic            cond;

  assign opcode = INSTRUCTION[6:0];
  assign funct3 = INSTRUCTION[14:12];
  assign funct7 = INSTRUCTION[31:25];

  // Decode; anything unrecognised stays an all-zero NOP
  always_comb begin
    id_ctrl = '0;
    imm_fmt = IMM_NONE;
    if (!RESET) begin
      case (opcode)
        OP_LUI: begin
          id_ctrl.alu_sel = ALU_PASS_B; id_ctrl.op2_imm = 1'b1; imm_fmt = IMM_U;
          id_ctrl.reg_write_en = 1'b1; id_ctrl.wb_sel = WB_ALU;
        end
        OP_AUIPC: begin
          id_ctrl.op1_pc = 1'b1; id_ctrl.op2_imm = 1'b1; imm_fmt = IMM_U;
          id_ctrl.reg_write_en = 1'b1; id_ctrl.wb_sel = WB_ALU;
        end
        OP_JAL: begin
          id_ctrl.op1_pc = 1'b1; id_ctrl.op2_imm = 1'b1; imm_fmt = IMM_J;
          id_ctrl.branch_sel = {1'b1, BR_JUMP};
          id_ctrl.reg_write_en = 1'b1; id_ctrl.wb_sel = WB_PC4;
        end
        OP_JALR: begin
          id_ctrl.op2_imm = 1'b1; id_ctrl.jalr = 1'b1; imm_fmt = IMM_I;
          id_ctrl.branch_sel = {1'b1, BR_JUMP};
          id_ctrl.reg_write_en = 1'b1; id_ctrl.wb_sel = WB_PC4;
        end
        OP_BRANCH: begin
          if (funct3 != 3'b010 && funct3 != 3'b011) begin
            id_ctrl.op1_pc = 1'b1; id_ctrl.op2_imm = 1'b1; imm_fmt = IMM_B;
            id_ctrl.branch_sel = {1'b1, funct3};
          end
        end
        OP_LOAD: begin
          id_ctrl.op2_imm = 1'b1; imm_fmt = IMM_I;
          id_ctrl.mem_read = {1'b1, funct3};
          id_ctrl.reg_write_en = 1'b1; id_ctrl.wb_sel = WB_MEM;
        end
        OP_STORE: begin
          id_ctrl.op2_imm = 1'b1; imm_fmt = IMM_S;
          id_ctrl.mem_write = {1'b1, funct3[1:0]};
        end
        OP_IMM: begin
          id_ctrl.alu_sel = {2'b00, (funct3 == 3'b101) & INSTRUCTION[30], funct3};
          id_ctrl.op2_imm = 1'b1; imm_fmt = IMM_I;
          id_ctrl.reg_write_en = 1'b1; id_ctrl.wb_sel = WB_ALU;
        end
        OP_REG: begin
          if (funct7 == 7'b0000001) id_ctrl.alu_sel = {3'b010, funct3};
          else                      id_ctrl.alu_sel = {2'b00, INSTRUCTION[30], funct3};
          id_ctrl.reg_write_en = 1'b1; id_ctrl.wb_sel = WB_ALU;
        end
        default: ;
      endcase
    end
  end

  assign id_imm = imm_gen(INSTRUCTION, imm_fmt);

  // A bubble keeps the instruction but drops every side effect
  always_comb begin
    cap_ctrl = id_ctrl;
    if (FLUSH || STALL) begin
      cap_ctrl.branch_sel   = '0;
      cap_ctrl.mem_read     = '0;
      cap_ctrl.mem_write    = '0;
      cap_ctrl.reg_write_en = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ex_ctrl  <= '0;
      ex_pc    <= '0;
      ex_data1 <= '0;
      ex_data2 <= '0;
      ex_imm   <= '0;
      ex_rd    <= '0;
    end else begin
      ex_ctrl  <= cap_ctrl;
      ex_pc    <= PC_IN;
      ex_data1 <= DATA1;
      ex_data2 <= DATA2;
      ex_imm   <= id_imm;
      ex_rd    <= INSTRUCTION[11:7];
    end
  end

  assign op1 = ex_ctrl.op1_pc  ? ex_pc  : ex_data1;
  assign op2 = ex_ctrl.op2_imm ? ex_imm : ex_data2;

  rv32_alu_core u_alu (
    .alu_sel (ex_ctrl.alu_sel),
    .op_a    (op1),
    .op_b    (op2),
    .result  (alu_res)
  );

  // Branch compare always looks at the raw register operands
  always_comb begin
    cond = 1'b0;
    case (ex_ctrl.branch_sel[2:0])
      BR_BEQ:  cond = (ex_data1 == ex_data2);
      BR_BNE:  cond = (ex_data1 != ex_data2);
      BR_JUMP: cond = 1'b1;
      BR_BLT:  cond = ($signed(ex_data1) < $signed(ex_data2));
      BR_BGE:  cond = ($signed(ex_data1) >= $signed(ex_data2));
      BR_BLTU: cond = (ex_data1 < ex_data2);
      BR_BGEU: cond = (ex_data1 >= ex_data2);
      default: cond = 1'b0;
    endcase
  end

  assign ALU_OUT          = ex_ctrl.jalr ? {alu_res[XLEN-1:1], 1'b0} : alu_res;
  assign BRANCH_TAKEN     = ex_ctrl.branch_sel[3] & cond;
  assign MEM_READ         = ex_ctrl.mem_read;
  assign MEM_WRITE        = ex_ctrl.mem_write;
  assign REG_WRITE_EN     = ex_ctrl.reg_write_en;
  assign REG_WRITE_SELECT = ex_ctrl.wb_sel;
  assign RD_ADDR          = ex_rd;

endmodule

// File: tb/tb_rv32_decode_execute.sv
// Directed scoreboard bench for rv32_decode_execute.
module tb_rv32_decode_execute;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC_IN;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic        FLUSH;
  logic        STALL;
  logic [31:0] ALU_OUT;
  logic        BRANCH_TAKEN;
  logic [3:0]  MEM_READ;
  logic [2:0]  MEM_WRITE;
  logic        REG_WRITE_EN;
  logic [1:0]  REG_WRITE_SELECT;
  logic [4:0]  RD_ADDR;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       tag;
    logic [31:0] alu;
    bit          chk_alu;
    logic        taken;
    logic [3:0]  mr;
    logic [2:0]  mw;
    logic        rwe;
    logic [1:0]  wsel;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];

  rv32_decode_execute dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .INSTRUCTION      (INSTRUCTION),
    .PC_IN            (PC_IN),
    .DATA1            (DATA1),
    .DATA2            (DATA2),
    .FLUSH            (FLUSH),
    .STALL            (STALL),
    .ALU_OUT          (ALU_OUT),
    .BRANCH_TAKEN     (BRANCH_TAKEN),
    .MEM_READ         (MEM_READ),
    .MEM_WRITE        (MEM_WRITE),
    .REG_WRITE_EN     (REG_WRITE_EN),
    .REG_WRITE_SELECT (REG_WRITE_SELECT),
    .RD_ADDR          (RD_ADDR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic fl, input logic st, input logic rst,
                      input logic [31:0] alu, input bit chk_alu, input logic taken,
                      input logic [3:0] mr, input logic [2:0] mw, input logic rwe,
                      input logic [1:0] wsel, input logic [4:0] rd);
    exp_t e;
    @(negedge CLK);
    INSTRUCTION = ins; PC_IN = pc; DATA1 = d1; DATA2 = d2;
    FLUSH = fl; STALL = st; RESET = rst;
    e.tag = tag; e.alu = alu; e.chk_alu = chk_alu; e.taken = taken; e.mr = mr;
    e.mw = mw; e.rwe = rwe; e.wsel = wsel; e.rd = rd;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL %s scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      if (e.chk_alu) chk(e.tag, "alu_out", ALU_OUT, e.alu);
      chk(e.tag, "branch_taken", 32'(BRANCH_TAKEN), 32'(e.taken));
      chk(e.tag, "mem_read", 32'(MEM_READ), 32'(e.mr));
      chk(e.tag, "mem_write", 32'(MEM_WRITE), 32'(e.mw));
      chk(e.tag, "reg_write_en", 32'(REG_WRITE_EN), 32'(e.rwe));
      chk(e.tag, "reg_write_select", 32'(REG_WRITE_SELECT), 32'(e.wsel));
      chk(e.tag, "rd_addr", 32'(RD_ADDR), 32'(e.rd));
    end
  endtask

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BLT  = 32'h0020C463;
  localparam logic [31:0] I_BLTU = 32'h0020E463;
  localparam logic [31:0] I_DIV  = 32'h0220C1B3;
  localparam logic [31:0] I_REM  = 32'h0220E1B3;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_JALR = 32'h00308167;
  localparam logic [31:0] I_LW   = 32'h0040A283;
  localparam logic [31:0] I_SW   = 32'h0020A423;

  initial begin
    RESET = 1'b1; INSTRUCTION = '0; PC_IN = '0; DATA1 = '0; DATA2 = '0;
    FLUSH = 1'b0; STALL = 1'b0;

    //   tag          instr   pc       d1            d2            fl st rs  alu           ca tk mr       mw      rwe wsel rd
    step("reset",     I_ADD,  32'h0,   32'd5,        32'd7,        0, 0, 1,  32'h0,        1, 0, 4'h0,    3'h0,   0,  2'd0, 5'd0);
    step("add",       I_ADD,  32'h0,   32'd5,        32'd7,        0, 0, 0,  32'd12,       1, 0, 4'h0,    3'h0,   1,  2'd2, 5'd3);
    step("sub",       I_SUB,  32'h0,   32'd5,        32'd7,        0, 0, 0,  32'hFFFFFFFE, 1, 0, 4'h0,    3'h0,   1,  2'd2, 5'd3);
    step("beq_t",     I_BEQ,  32'h100, 32'd9,        32'd9,        0, 0, 0,  32'h108,      1, 1, 4'h0,    3'h0,   0,  2'd0, 5'd8);
    step("beq_nt",    I_BEQ,  32'h100, 32'd9,        32'd8,        0, 0, 0,  32'h108,      1, 0, 4'h0,    3'h0,   0,  2'd0, 5'd8);
    step("blt",       I_BLT,  32'h100, 32'hFFFFFFFF, 32'd1,        0, 0, 0,  32'h108,      1, 1, 4'h0,    3'h0,   0,  2'd0, 5'd8);
    step("bltu",      I_BLTU, 32'h100, 32'hFFFFFFFF, 32'd1,        0, 0, 0,  32'h108,      1, 0, 4'h0,    3'h0,   0,  2'd0, 5'd8);
    step("div0",      I_DIV,  32'h0,   32'h1234,     32'h0,        0, 0, 0,  32'hFFFFFFFF, 1, 0, 4'h0,    3'h0,   1,  2'd2, 5'd3);
    step("rem0",      I_REM,  32'h0,   32'h1234,     32'h0,        0, 0, 0,  32'h1234,     1, 0, 4'h0,    3'h0,   1,  2'd2, 5'd3);
    step("div_ovf",   I_DIV,  32'h0,   32'h80000000, 32'hFFFFFFFF, 0, 0, 0,  32'h80000000, 1, 0, 4'h0,    3'h0,   1,  2'd2, 5'd3);
    step("lui",       I_LUI,  32'h0,   32'h0,        32'h0,        0, 0, 0,  32'h12345000, 1, 0, 4'h0,    3'h0,   1,  2'd2, 5'd1);
    step("add_flush", I_ADD,  32'h0,   32'd5,        32'd7,        1, 0, 0,  32'd12,       1, 0, 4'h0,    3'h0,   0,  2'd2, 5'd3);
    step("add_stall", I_ADD,  32'h0,   32'd5,        32'd7,        0, 1, 0,  32'd12,       1, 0, 4'h0,    3'h0,   0,  2'd2, 5'd3);
    step("jal",       I_JAL,  32'h200, 32'h0,        32'h0,        0, 0, 0,  32'h208,      1, 1, 4'h0,    3'h0,   1,  2'd0, 5'd1);
    step("jal_flush", I_JAL,  32'h200, 32'h0,        32'h0,        1, 0, 0,  32'h208,      1, 0, 4'h0,    3'h0,   0,  2'd0, 5'd1);
    step("jalr",      I_JALR, 32'h0,   32'h1000,     32'h0,        0, 0, 0,  32'h1002,     1, 1, 4'h0,    3'h0,   1,  2'd0, 5'd2);
    step("lw",        I_LW,   32'h0,   32'h100,      32'h0,        0, 0, 0,  32'h104,      1, 0, 4'b1010, 3'h0,   1,  2'd1, 5'd5);
    step("lw_stall",  I_LW,   32'h0,   32'h100,      32'h0,        0, 1, 0,  32'h104,      1, 0, 4'h0,    3'h0,   0,  2'd1, 5'd5);
    step("sw",        I_SW,   32'h0,   32'h100,      32'h55,       0, 0, 0,  32'h108,      1, 0, 4'h0,    3'b110, 0,  2'd0, 5'd8);
    step("illegal",   32'hFFFFFFFF, 32'h0, 32'd3,    32'd4,        0, 0, 0,  32'h0,        0, 0, 4'h0,    3'h0,   0,  2'd0, 5'd31);
    step("zero_word", 32'h0,  32'h0,   32'd3,        32'd4,        0, 0, 0,  32'h0,        0, 0, 4'h0,    3'h0,   0,  2'd0, 5'd0);
    step("add_pre",   I_ADD,  32'h0,   32'd5,        32'd7,        0, 0, 0,  32'd12,       1, 0, 4'h0,    3'h0,   1,  2'd2, 5'd3);
    step("mid_reset", I_ADD,  32'h0,   32'd5,        32'd7,        1, 1, 1,  32'h0,        1, 0, 4'h0,    3'h0,   0,  2'd0, 5'd0);
    step("recover",   I_ADD,  32'h0,   32'd20,       32'd22,       0, 0, 0,  32'd42,       1, 0, 4'h0,    3'h0,   1,  2'd2, 5'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rv32_decode_execute.md
Name: rv32_decode_execute

Overview:
- RV32IM decode + execute slice of the 5-stage CPU.
- Decodes the ID-stage instruction (control and immediate) and latches it with operands into an ID/EX register.
- From the registered values it computes the ALU result and the branch decision.
- The ALU result feeds memory address, writeback and the branch/jump target. BRANCH_TAKEN drives PC select and the pipeline flush.

Parameters:
- XLEN, 32, datapath width (fixed; RV32 only).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high.
- INSTRUCTION  in  32  ID-stage instruction word.
- PC_IN  in  32  PC of INSTRUCTION.
- DATA1  in  32  rs1 value, already forwarded.
- DATA2  in  32  rs2 value, already forwarded.
- FLUSH  in  1  insert bubble: latch instruction but kill its side effects.
- STALL  in  1  load-use hazard; same bubble effect as FLUSH.
- ALU_OUT  out  32  ALU result / branch target.
- BRANCH_TAKEN  out  1  redirect PC to ALU_OUT.
- MEM_READ  out  4  [3]=enable, [2:0]=funct3 (LB/LH/LW/LBU/LHU).
- MEM_WRITE  out  3  [2]=enable, [1:0]=funct3 (SB/SH/SW).
- REG_WRITE_EN  out  1  writeback enable.
- REG_WRITE_SELECT  out  2  0=PC+4, 1=memory, 2=ALU.
- RD_ADDR  out  5  INSTRUCTION[11:7], registered.

Behaviour:
- Decode is combinational from INSTRUCTION.
  - Registered on each CLK edge: control fields, PC, DATA1, DATA2, immediate, rd.
  - ALU and branch logic are combinational on the registered values, so results appear 1 cycle after the instruction is presented.
- ALU select is 6 bits: [5]=pass op2 (LUI), [4]=M-extension, [3]=alt (SUB/SRA), [2:0]=funct3.
  - Ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - Shifts use op2[4:0].
  - M-extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Divide by 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - DIV 0x80000000/-1 returns 0x80000000; REM in that case returns 0.
- Operand select: op1 = PC for AUIPC/JAL/branches, else DATA1. op2 = immediate for all non-R-type, else DATA2.
- Immediates: I, S, B, U, J formats, sign-extended.
- Branch select is 4 bits: [3]=enable, [2:0]=funct3 for BEQ/BNE/BLT/BGE/BLTU/BGEU; 010 = unconditional (JAL/JALR).
  - Compare uses registered DATA1/DATA2, never the ALU inputs.
- Branch/jump target:
  - Branches and JAL: ALU_OUT = PC+imm.
  - JALR: ALU_OUT = (rs1+imm) with bit0 cleared.
- Writeback: JAL/JALR select PC+4 (REG_WRITE_SELECT=0); loads select 1; ALU and LUI/AUIPC select 2.
- Stores and branches: REG_WRITE_EN=0.
- Unknown opcode or all-zero word decodes as NOP: all enables 0, ALU select 0.
- FLUSH or STALL at a capture edge:
  - Instruction still latched.
  - Latched branch enable, MEM_READ, MEM_WRITE and REG_WRITE_EN forced to 0.
  - ALU selection retained.
- Reset:
  - All registered state is 0, so ALU_OUT=0, BRANCH_TAKEN=0 and every enable is 0.
  - RESET also forces decode outputs to 0.
  - Reset overrides FLUSH/STALL.
  - Reset mid-operation discards the in-flight instruction.

Decomposition:
- Shared package rv32_pkg holds:
  - opcode constants;
  - ALU select encodings;
  - branch-select encodings;
  - writeback-select encodings;
  - immediate-format constants.
- One natural combinational sub-module, rv32_alu_core: the ALU, including MUL/DIV.
- Decode, immediate generation and branch compare stay in the top.

Test Plan:
- Arithmetic:
  - 0x002081B3 (add x3,x1,x2), DATA1=5, DATA2=7 → next cycle ALU_OUT=12, REG_WRITE_EN=1, RD_ADDR=3, REG_WRITE_SELECT=2.
  - 0x402081B3 (sub), same operands → ALU_OUT=0xFFFFFFFE.
- BEQ: 0x00208463, PC_IN=0x100.
  - DATA1=DATA2=9 → BRANCH_TAKEN=1, ALU_OUT=0x108.
  - DATA2=8 → BRANCH_TAKEN=0.
- Signed vs unsigned compare, DATA1=0xFFFFFFFF, DATA2=1:
  - BLT 0x0020C463 → taken.
  - BLTU 0x0020E463 → not taken.
- M-extension corners, DATA1=0x1234, DATA2=0:
  - DIV 0x0220C1B3 → 0xFFFFFFFF.
  - REM 0x0220E1B3 → 0x1234.
  - DIV with DATA1=0x80000000, DATA2=0xFFFFFFFF → 0x80000000.
- LUI 0x123450B7 → ALU_OUT=0x12345000, RD_ADDR=1. Then the same add with FLUSH=1 → REG_WRITE_EN=0, BRANCH_TAKEN=0, MEM_WRITE=0.
- Reset:
  - RESET=1 one cycle after an add → all outputs 0.
  - Illegal word 0xFFFFFFFF → all enables 0.
